// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit.
// - state_t       : FSM state encoding (also exported on state_o for debug)
// - iclass_t      : instruction class derived from the major opcode
// - OP_*          : RV32 major-opcode constants (IR[6:0])
// - ALU_*         : 4-bit ALU operation codes, shared with the ALU
// - F3_*          : branch funct3 values
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_RALU,
    CL_IALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_ILLEGAL
  } iclass_t;

  localparam logic [6:0] OP_RALU   = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of the latched instruction into ALU controls.
// Ports:
//   major   : IR[6:0] major opcode
//   funct3  : IR[14:12]
//   bit30   : IR[30] (selects SUB for R-type funct3=000)
//   alu_op  : 4-bit ALU operation
//   alu_src : 1 = immediate operand, 0 = RS2
//   cls     : instruction class
module alu_op_decode
  import cu_pkg::*;
(
  input  logic [6:0] major,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [3:0] alu_op,
  output logic       alu_src,
  output iclass_t    cls
);

  logic [3:0] arith_op;

  // Arithmetic op from funct3; unlisted funct3 (011) falls back to ADD.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = ALU_ADD;
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b100:  arith_op = ALU_XOR;
      3'b001:  arith_op = ALU_SLL;
      3'b101:  arith_op = ALU_SRL;
      3'b010:  arith_op = ALU_SLT;
      default: arith_op = ALU_ADD;
    endcase
  end

  always_comb begin
    cls     = CL_ILLEGAL;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    case (major)
      OP_RALU: begin
        cls    = CL_RALU;
        // SUB only exists in the register form; I-type bit30 is immediate data.
        alu_op = (funct3 == 3'b000 && bit30) ? ALU_SUB : arith_op;
      end
      OP_IALU: begin
        cls     = CL_IALU;
        alu_op  = arith_op;
        alu_src = 1'b1;
      end
      OP_LOAD: begin
        cls     = CL_LOAD;
        alu_src = 1'b1;
      end
      OP_STORE: begin
        cls     = CL_STORE;
        alu_src = 1'b1;
      end
      OP_BRANCH: begin
        cls    = CL_BRANCH;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath controls from the current state and the latched instruction.
// Ports:
//   clk, reset (async, active low)
//   instr     : ROM word at PC, latched into IR when leaving FETCH
//   alu_zero  : ALU zero flag, used for branch resolution in EXEC
//   opcode, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_we : datapath controls
//   halted    : set while parked in HALT after an illegal instruction
//   state_o   : current FSM state (debug)
//   retired   : retired-instruction counter, wraps at 2^COUNT_W
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  output logic [3:0]         opcode,
  output logic               ALUsrc,
  output logic               RegWrite,
  output logic               MemRW,
  output logic               MemtoReg,
  output logic               PCsrc,
  output logic               pc_we,
  output logic               halted,
  output logic [2:0]         state_o,
  output logic [COUNT_W-1:0] retired
);

  state_t           state, state_nxt;
  logic [31:0]      ir;
  logic [COUNT_W-1:0] cnt;
  logic [3:0]       dec_op;
  logic             dec_src;
  iclass_t          cls;

  // Only the major opcode, funct3 and bit30 steer control; the rest of IR
  // belongs to the datapath (register indices, immediates).
  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  alu_op_decode u_dec (
    .major   (ir[6:0]),
    .funct3  (ir[14:12]),
    .bit30   (ir[30]),
    .alu_op  (dec_op),
    .alu_src (dec_src),
    .cls     (cls)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // IR loads on the edge leaving FETCH; instr is ignored everywhere else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 ir <= '0;
    else if (state == S_FETCH)  ir <= instr;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = (cls == CL_ILLEGAL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls)
          CL_LOAD, CL_STORE: state_nxt = S_MEM;
          CL_BRANCH:         state_nxt = S_FETCH;
          default:           state_nxt = S_WB;
        endcase
      end
      S_MEM:    state_nxt = (cls == CL_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Output logic. Everything is a function of state (plus IR and, for the
  // branch decision, alu_zero), so an async reset kills any pending commit
  // in the same cycle.
  always_comb begin
    opcode   = 4'b0000;
    ALUsrc   = 1'b0;
    RegWrite = 1'b0;
    MemRW    = 1'b0;
    MemtoReg = 1'b0;
    PCsrc    = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;
    case (state)
      S_EXEC: begin
        opcode = dec_op;
        ALUsrc = dec_src;
        if (cls == CL_BRANCH) begin
          pc_we = 1'b1;
          PCsrc = ((ir[14:12] == F3_BEQ) &&  alu_zero) ||
                  ((ir[14:12] == F3_BNE) && !alu_zero);
        end
      end
      S_MEM: begin
        opcode   = dec_op;
        ALUsrc   = dec_src;
        MemRW    = (cls == CL_STORE);
        MemtoReg = (cls == CL_LOAD);
        pc_we    = (cls == CL_STORE);
      end
      S_WB: begin
        opcode   = dec_op;
        ALUsrc   = dec_src;
        RegWrite = 1'b1;
        MemtoReg = (cls == CL_LOAD);
        pc_we    = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Retired counter advances exactly on commit cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (pc_we) cnt <= cnt + 1'b1;
  end

  assign retired = cnt;
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam int CW = 4;  // narrow counter so wrap-around is reached

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   instr = '0;
  logic          alu_zero = 1'b0;
  logic [3:0]    opcode;
  logic          ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_we, halted;
  logic [2:0]    state_o;
  logic [CW-1:0] retired;

  int total = 0;
  int bad   = 0;
  int unsigned exp_ret = 0;

  multicycle_control_unit #(.COUNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .alu_zero (alu_zero),
    .opcode   (opcode),
    .ALUsrc   (ALUsrc),
    .RegWrite (RegWrite),
    .MemRW    (MemRW),
    .MemtoReg (MemtoReg),
    .PCsrc    (PCsrc),
    .pc_we    (pc_we),
    .halted   (halted),
    .state_o  (state_o),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Assert reset while the clock is low, check the reset state, release on
  // the next falling edge so the caller starts at the top of a FETCH cycle.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_outs", {opcode, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_we, halted}, 0);
    chk("rst_retired", 32'(retired), 0);
    exp_ret = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference model: an instruction is a list of visited states plus a set of
  // class-level facts; every cycle's outputs follow from those facts.
  // abort_at >= 0 asserts reset during that cycle of the instruction.
  task automatic run_instr(input logic [31:0] w, input logic z, input int abort_at);
    logic [3:0] f3_tab [8] = '{4'h0, 4'h5, 4'h7, 4'h0, 4'h4, 4'h6, 4'h3, 4'h2};
    int seq[$];
    string cname;
    logic [3:0] op;
    logic src, taken, is_ld, is_st;
    logic [2:0] f3;
    f3 = w[14:12];
    src = 1'b0; op = 4'h0; taken = 1'b0;
    case (w[6:0])
      7'b0110011: begin cname = "R";  seq = '{0,1,2,4};
                    op = (f3 == 0 && w[30]) ? 4'h1 : f3_tab[f3]; end
      7'b0010011: begin cname = "I";  seq = '{0,1,2,4}; op = f3_tab[f3]; src = 1; end
      7'b0000011: begin cname = "LD"; seq = '{0,1,2,3,4}; src = 1; end
      7'b0100011: begin cname = "ST"; seq = '{0,1,2,3}; src = 1; end
      7'b1100011: begin cname = "BR"; seq = '{0,1,2}; op = 4'h1;
                    taken = (f3 == 0 && z) || (f3 == 1 && !z); end
      default:    begin cname = "ILL"; seq = '{0,1}; end
    endcase
    is_ld = (cname == "LD");
    is_st = (cname == "ST");
    for (int k = 0; k < seq.size(); k++) begin
      int s;
      logic act, last;
      s = seq[k];
      instr    = (k == 0) ? w : $urandom;
      alu_zero = (s == 2) ? z : 1'($urandom);
      #1;
      act  = (s >= 2);
      last = (k == seq.size() - 1) && (cname != "ILL");
      chk({cname, "_state"},    32'(state_o),  32'(s));
      chk({cname, "_opcode"},   32'(opcode),   act ? 32'(op) : 0);
      chk({cname, "_ALUsrc"},   32'(ALUsrc),   32'(act && src));
      chk({cname, "_RegWrite"}, 32'(RegWrite), 32'(s == 4));
      chk({cname, "_MemRW"},    32'(MemRW),    32'(s == 3 && is_st));
      chk({cname, "_MemtoReg"}, 32'(MemtoReg), 32'(is_ld && (s == 3 || s == 4)));
      chk({cname, "_PCsrc"},    32'(PCsrc),    32'(s == 2 && taken));
      chk({cname, "_pc_we"},    32'(pc_we),    32'(last));
      chk({cname, "_halted"},   32'(halted),   0);
      chk({cname, "_retired"},  32'(retired),  exp_ret);
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_state",    32'(state_o),  0);
        chk("abort_RegWrite", 32'(RegWrite), 0);
        chk("abort_pc_we",    32'(pc_we),    0);
        chk("abort_MemRW",    32'(MemRW),    0);
        chk("abort_retired",  32'(retired),  0);
        exp_ret = 0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (cname == "ILL") begin
      for (int c = 0; c < 20; c++) begin
        instr    = $urandom;
        alu_zero = 1'($urandom);
        #1;
        chk("halt_state",   32'(state_o), 5);
        chk("halt_halted",  32'(halted),  1);
        chk("halt_enables", {RegWrite, MemRW, pc_we}, 0);
        chk("halt_retired", 32'(retired), exp_ret);
        @(negedge clk);
      end
    end else begin
      exp_ret = (exp_ret + 1) % (1 << CW);
    end
  endtask

  initial begin
    logic [6:0] majors [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    #2;
    do_reset();

    // Directed instructions
    run_instr(32'h002081B3, 1'b0, -1);  // ADD x3,x1,x2
    chk("add_retired", 32'(retired), 1);
    run_instr(32'h0040A183, 1'b0, -1);  // LW
    run_instr(32'h0030A223, 1'b0, -1);  // SW
    run_instr(32'h00208463, 1'b1, -1);  // BEQ taken
    run_instr(32'h00208463, 1'b0, -1);  // BEQ not taken
    run_instr(32'h40208133, 1'b0, -1);  // SUB
    run_instr(32'h00209463, 1'b0, -1);  // BNE taken
    run_instr(32'h00209463, 1'b1, -1);  // BNE not taken
    run_instr(32'h4050D093, 1'b0, -1);  // I-type funct3=101 with bit30 -> SRL

    // Random legal instruction stream; counter wraps several times
    for (int n = 0; n < 150; n++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = majors[$urandom_range(0, 4)];
      run_instr(w, 1'($urandom), -1);
    end

    // Reset in the WB cycle of an ADD: no commit
    do_reset();
    run_instr(32'h002081B3, 1'b0, 3);
    chk("post_abort_retired", 32'(retired), 0);

    // Illegal instruction parks in HALT until reset
    run_instr(32'hFFFFFFFF, 1'b0, -1);
    do_reset();
    run_instr(32'h002081B3, 1'b0, -1);
    run_instr({$urandom_range(0, 32'h1FFFFFF), 7'b1111111}, 1'b0, -1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
